// File: rtl/pc_seq_pkg.sv
// Shared types and reset contents for the fetch-stage PC sequencer.
package pc_seq_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int PTR_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Reset pattern repeats every four entries; entry 0 of each group is a -16 backward hop.
  function automatic logic [PC_W_DEF-1:0] default_target(input int idx);
    logic [1:0] sel;
    logic [PC_W_DEF-1:0] val;
    sel = idx[1:0];
    case (sel)
      2'd0:    val = 10'h3F0;
      2'd1:    val = 10'h003;
      2'd2:    val = 10'h007;
      default: val = 10'h001;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/branch_target_table.sv
// Writable branch-target table: async reset to default targets, one sync write, one comb read.
module branch_target_table
  import pc_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  localparam int DEPTH = 2 ** PTR_W;

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= PC_W'(default_target(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle write and read of one entry returns the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: start/run/halt sequencing, table-driven branches, run-cycle count.
//
// state | meaning
// IDLE  | after reset, waiting for Start
// RUN   | fetching; PC advances, stalls or branches; counter runs
// DONE  | halted; PC and counter frozen until Start
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              PTR_W      = PTR_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchTaken,
  input  logic             BranchRel,
  input  logic [PTR_W-1:0] BranchPtr,
  input  logic             CfgWe,
  input  logic [PTR_W-1:0] CfgAddr,
  input  logic [PC_W-1:0]  CfgData,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  target;

  branch_target_table #(
    .PC_W  (PC_W),
    .PTR_W (PTR_W)
  ) u_tbl (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (CfgWe),
    .waddr (CfgAddr),
    .wdata (CfgData),
    .raddr (BranchPtr),
    .rdata (target)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // Stall outranks Halt so a stalled halt is re-presented on the next cycle.
        if (Stall) begin
          pc_d = pc_q;
        end else if (Halt) begin
          state_d = DONE;
        end else if (BranchEn && BranchTaken) begin
          pc_d = BranchRel ? (pc_q + target) : target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_ADDR;
        cnt_d   = '0;
      end
    endcase
  end

  assign PC       = pc_q;
  assign CycleCnt = cnt_q;
  assign Running  = (state_q == RUN);
  assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model; a 4-bit-counter copy checks saturation.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start, Stall, Halt, BranchEn, BranchTaken, BranchRel, CfgWe;
  logic [3:0] BranchPtr, CfgAddr;
  logic [9:0] CfgData;

  logic [9:0]  PC, PC4;
  logic        Running, Done, Running4, Done4;
  logic [15:0] CycleCnt;
  logic [3:0]  CycleCnt4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_sequencer u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .BranchTaken(BranchTaken), .BranchRel(BranchRel),
    .BranchPtr(BranchPtr), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgData(CfgData),
    .PC(PC), .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
  );

  pc_sequencer #(.CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .BranchTaken(BranchTaken), .BranchRel(BranchRel),
    .BranchPtr(BranchPtr), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgData(CfgData),
    .PC(PC4), .Running(Running4), .Done(Done4), .CycleCnt(CycleCnt4)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting, 1 = fetching, 2 = halted.
  int m_mode, m_pc, m_cnt;
  int m_tbl [16];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = 0;
      m_pc   = 0;
      m_cnt  = 0;
      for (int i = 0; i < 16; i++) begin
        case (i % 4)
          0: m_tbl[i] = 'h3F0;
          1: m_tbl[i] = 'h003;
          2: m_tbl[i] = 'h007;
          default: m_tbl[i] = 'h001;
        endcase
      end
    end else begin
      if (m_mode == 1) begin
        m_cnt = m_cnt + 1;
        if (Stall) begin
        end else if (Halt) begin
          m_mode = 2;
        end else if (BranchEn && BranchTaken) begin
          m_pc = BranchRel ? (m_pc + m_tbl[BranchPtr]) % 1024 : m_tbl[BranchPtr];
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end else if (Start) begin
        m_mode = 1;
        m_pc   = 0;
        m_cnt  = 0;
      end
      if (CfgWe) m_tbl[CfgAddr] = int'(CfgData);
    end
  end

  always @(negedge Clk) begin
    check("pc",       int'(PC),        m_pc);
    check("running",  int'(Running),   int'(m_mode == 1));
    check("done",     int'(Done),      int'(m_mode == 2));
    check("cnt16",    int'(CycleCnt),  (m_cnt > 65535) ? 65535 : m_cnt);
    check("pc_w4",    int'(PC4),       m_pc);
    check("cnt4",     int'(CycleCnt4), (m_cnt > 15) ? 15 : m_cnt);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clr;
    Start = 0; Stall = 0; Halt = 0; BranchEn = 0; BranchTaken = 0; BranchRel = 0;
    BranchPtr = 0; CfgWe = 0; CfgAddr = 0; CfgData = 0;
  endtask

  task automatic branch(input logic rel, input logic [3:0] ptr);
    BranchEn = 1; BranchTaken = 1; BranchRel = rel; BranchPtr = ptr;
  endtask

  task automatic cfg(input logic [3:0] addr, input logic [9:0] data);
    CfgWe = 1; CfgAddr = addr; CfgData = data;
  endtask

  initial begin
    clr();
    Reset_n = 0;
    tick(2);
    check("rst_pc", int'(PC), 'h000);
    check("rst_running", int'(Running), 0);
    check("rst_done", int'(Done), 0);
    check("rst_cnt", int'(CycleCnt), 0);
    Reset_n = 1;
    tick();
    check("idle_hold", int'(Running), 0);

    // Start and free-run
    Start = 1; tick(); Start = 0;
    check("start_pc", int'(PC), 'h000);
    check("start_running", int'(Running), 1);
    check("start_cnt", int'(CycleCnt), 0);
    tick();
    check("run_pc1", int'(PC), 'h001);
    check("run_cnt1", int'(CycleCnt), 1);
    tick();
    check("run_pc2", int'(PC), 'h002);
    tick(18);
    check("run_pc20", int'(PC), 'h014);
    check("run_cnt20", int'(CycleCnt), 'h014);
    check("sat_cnt4", int'(CycleCnt4), 'hF);

    // Halt, restart, branches
    Halt = 1; tick(); Halt = 0;
    check("halt_done", int'(Done), 1);
    check("halt_pc", int'(PC), 'h014);
    tick();
    check("done_cnt_hold", int'(CycleCnt), 'h015);
    Start = 1; tick(); Start = 0;
    check("restart_pc", int'(PC), 'h000);
    check("restart_cnt", int'(CycleCnt), 0);
    tick(5);
    check("pc5", int'(PC), 'h005);
    branch(1, 0); tick();
    check("rel_neg16", int'(PC), 'h3F5);
    branch(0, 2); tick();
    check("abs_ptr2", int'(PC), 'h007);
    BranchTaken = 0; tick();
    check("not_taken", int'(PC), 'h008);
    clr();

    // Wrap cases
    cfg(6, 10'h3FF); tick(); clr();
    check("cfg_pc", int'(PC), 'h009);
    branch(0, 6); tick(); clr();
    check("abs_3ff", int'(PC), 'h3FF);
    tick();
    check("wrap_inc", int'(PC), 'h000);
    cfg(7, 10'h3FE); tick(); clr();
    branch(0, 7); tick();
    check("abs_3fe", int'(PC), 'h3FE);
    branch(1, 1); tick(); clr();
    check("rel_wrap", int'(PC), 'h001);
    Stall = 1; Halt = 1; branch(0, 2); tick(); clr();
    check("stall_halt_pc", int'(PC), 'h001);
    check("stall_halt_run", int'(Running), 1);
    Halt = 1; tick(); clr();
    check("halt_alone", int'(Done), 1);
    branch(0, 2); tick(); clr();
    check("done_frozen", int'(PC), 'h001);

    // Write/read collision on one entry
    Start = 1; tick(); clr();
    cfg(5, 10'h155); branch(0, 5); tick();
    check("collide_old", int'(PC), 'h003);
    CfgWe = 0; tick(); clr();
    check("collide_new", int'(PC), 'h155);

    // Asynchronous reset mid-run
    cfg(8, 10'h0A2); tick(); clr();
    branch(0, 8); tick(); clr();
    check("pc_0a2", int'(PC), 'h0A2);
    #2 Reset_n = 0;
    #1;
    check("arst_pc", int'(PC), 'h000);
    check("arst_running", int'(Running), 0);
    check("arst_cnt", int'(CycleCnt), 0);
    tick();
    Reset_n = 1;
    tick();
    check("post_rst_idle", int'(Running), 0);
    Start = 1; tick(); clr();
    branch(0, 5); tick(); clr();
    check("tbl5_default", int'(PC), 'h003);
    Halt = 1; tick(); clr();
    check("done_again", int'(Done), 1);
    Start = 1; tick(); clr();
    check("restart2_pc", int'(PC), 'h000);
    check("restart2_cnt", int'(CycleCnt), 0);
    tick();
    check("restart2_cnt1", int'(CycleCnt), 1);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
